test_status_scanner: RTL and testbench

Parametrised, time-multiplexed test-status display driver for the board 7-segment bank. It holds one 3-bit test-status code per digit, decodes each code with the team's status glyph table, and scans the digits with a programmable refresh rate, anti-ghosting blanking and optional blinking of error codes. New status words enter through a valid/ready handshake and take effect only at a frame boundary, so the display never shows a torn update.

---
 rtl/test_status_scanner.sv | 140 ++++++++++++++
 tb/tb_test_status_scanner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/test_status_scanner.sv
// Time-multiplexed test-status display driver: per-digit 3-bit status codes, glyph decode,
// digit scanning with leading blank cycles, error blinking and frame-aligned word commit.
module test_status_scanner #(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 1000,
    parameter int BLANK_CYC = 1,
    parameter int BLINK_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [3*DIGITS-1:0]   load_codes,
    input  logic                  blink_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PW = (CLK_DIV > 1)   ? $clog2(CLK_DIV)   : 1;
    localparam int IW = (DIGITS > 1)    ? $clog2(DIGITS)    : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]     r_pcnt;
    logic [IW-1:0]     r_idx;
    logic [FW-1:0]     r_fcnt;
    logic              r_bphase;
    logic [2:0]        r_disp [DIGITS];
    logic [2:0]        r_pend [DIGITS];
    logic              r_pvalid;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_an;
    logic              r_frame;

    logic              w_tick;
    logic              w_fb;
    logic              w_accept;
    logic              w_commit;
    logic              w_blank;
    logic [2:0]        w_code;
    logic [DIGITS-1:0] w_onehot;
    logic [6:0]        w_seg_n;
    logic [DIGITS-1:0] w_an_n;

    function automatic logic [6:0] glyph(input logic [2:0] c);
        logic [6:0] g;
        if (c[2]) begin
            g = 7'b0000001;
        end else begin
            case (c[1:0])
                2'b00:   g = 7'b0001111;
                2'b01:   g = 7'b1011011;
                2'b10:   g = 7'b1001111;
                default: g = 7'b0001111;
            endcase
        end
        return g;
    endfunction

    assign load_ready = ~r_pvalid;
    assign seg        = r_seg;
    assign an         = r_an;
    assign frame      = r_frame;

    assign w_tick   = (r_pcnt == PW'(CLK_DIV - 1));
    assign w_fb     = w_tick && (r_idx == IW'(DIGITS - 1));
    // Accept and commit are mutually exclusive: one needs pvalid low, the other high.
    assign w_accept = load_valid & ~r_pvalid;
    assign w_commit = w_fb & r_pvalid;
    assign w_blank  = (r_pcnt < PW'(BLANK_CYC));
    assign w_code   = r_disp[r_idx];

    always_comb begin
        w_onehot = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_onehot[i] = (r_idx == IW'(i));
        end
    end

    always_comb begin
        w_an_n  = '0;
        w_seg_n = '0;
        if (!w_blank) begin
            w_an_n = w_onehot;
            if (!(blink_en && !r_bphase && w_code[2])) begin
                w_seg_n = glyph(w_code);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt   <= '0;
            r_idx    <= '0;
            r_fcnt   <= '0;
            r_bphase <= 1'b1;
            r_pvalid <= 1'b0;
            r_seg    <= '0;
            r_an     <= '0;
            r_frame  <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                r_disp[i] <= '0;
                r_pend[i] <= '0;
            end
        end else begin
            r_seg   <= w_seg_n;
            r_an    <= w_an_n;
            r_frame <= w_fb;

            if (w_tick) begin
                r_pcnt <= '0;
                r_idx  <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end

            if (w_fb) begin
                if (r_fcnt == FW'(BLINK_DIV - 1)) begin
                    r_fcnt   <= '0;
                    r_bphase <= ~r_bphase;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end

            if (w_accept) begin
                r_pvalid <= 1'b1;
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    r_pend[i] <= load_codes[3*i +: 3];
                end
            end else if (w_commit) begin
                r_pvalid <= 1'b0;
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    r_disp[i] <= r_pend[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_test_status_scanner.sv
// Directed bench for test_status_scanner with DIGITS=4, CLK_DIV=4, BLANK_CYC=1, BLINK_DIV=2.
module tb_test_status_scanner;

    localparam logic [6:0] G000 = 7'b0001111;
    localparam logic [6:0] G001 = 7'b1011011;
    localparam logic [6:0] G010 = 7'b1001111;
    localparam logic [6:0] G011 = 7'b0001111;
    localparam logic [6:0] G1XX = 7'b0000001;

    // Expected glyphs packed {digit3, digit2, digit1, digit0}
    localparam logic [27:0] GALL0  = {G000, G000, G000, G000};
    localparam logic [27:0] GA     = {G1XX, G010, G001, G000};
    localparam logic [27:0] GB     = {G011, G001, G1XX, G010};
    localparam logic [27:0] GC     = {G000, G1XX, G011, G001};
    localparam logic [27:0] GD     = {G1XX, G000, G010, G001};
    localparam logic [27:0] GD_OFF = {7'b0000000, G000, G010, G001};

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [11:0] load_codes;
    logic        blink_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int checks = 0;
    int errors = 0;

    test_status_scanner #(
        .DIGITS   (4),
        .CLK_DIV  (4),
        .BLANK_CYC(1),
        .BLINK_DIV(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_codes(load_codes),
        .blink_en  (blink_en),
        .seg       (seg),
        .an        (an),
        .frame     (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Steps through positions jf..jt of a 16-cycle frame (4 slots x 4 cycles, first cycle blank).
    task automatic check_slots(input string tag, input int unsigned jf, input int unsigned jt,
                               input logic [27:0] g);
        int unsigned d;
        int unsigned p;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        for (int unsigned j = jf; j <= jt; j++) begin
            step();
            d = j / 4;
            p = j % 4;
            exp_an  = (p == 0) ? 4'b0000 : 4'(1 << d);
            exp_seg = (p == 0) ? 7'b0000000 : g[d*7 +: 7];
            chk($sformatf("%s an j%0d", tag, j), 32'(an), 32'(exp_an));
            chk($sformatf("%s seg j%0d", tag, j), 32'(seg), 32'(exp_seg));
            chk($sformatf("%s frame j%0d", tag, j), 32'(frame), 32'(j == 15));
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_codes = '0;
        blink_en   = 1'b0;
        #2;
        chk("reset seg", 32'(seg), 32'h0);
        chk("reset an", 32'(an), 32'h0);
        chk("reset frame", 32'(frame), 32'h0);
        chk("reset ready", 32'(load_ready), 32'h1);
        step();
        step();
        rst = 1'b0;

        // F1: idle scan of all-000 codes
        check_slots("F1", 0, 15, GALL0);
        chk("F1 ready", 32'(load_ready), 32'h1);

        // F2: load A mid-frame, display unchanged until boundary
        check_slots("F2", 0, 2, GALL0);
        chk("F2 ready before accept", 32'(load_ready), 32'h1);
        load_valid = 1'b1;
        load_codes = {3'b100, 3'b010, 3'b001, 3'b000};
        check_slots("F2", 3, 3, GALL0);
        load_valid = 1'b0;
        load_codes = 12'hABC;
        chk("F2 ready after accept", 32'(load_ready), 32'h0);
        check_slots("F2", 4, 15, GALL0);
        chk("F2 ready after commit", 32'(load_ready), 32'h1);

        // F3: show A; accept B, then hold C across the commit cycle
        check_slots("F3", 0, 2, GA);
        load_valid = 1'b1;
        load_codes = {3'b011, 3'b001, 3'b101, 3'b010};
        check_slots("F3", 3, 3, GA);
        chk("F3 ready after B", 32'(load_ready), 32'h0);
        load_codes = {3'b000, 3'b100, 3'b011, 3'b001};
        check_slots("F3", 4, 14, GA);
        chk("F3 ready held", 32'(load_ready), 32'h0);
        check_slots("F3", 15, 15, GA);
        chk("F3 ready after commit", 32'(load_ready), 32'h1);

        // F4: show B; C accepted on first cycle after commit
        check_slots("F4", 0, 0, GB);
        load_valid = 1'b0;
        load_codes = 12'h777;
        chk("F4 ready after C", 32'(load_ready), 32'h0);
        check_slots("F4", 1, 15, GB);
        chk("F4 ready after commit", 32'(load_ready), 32'h1);

        // F5: show C; load D with an error code on digit 3
        load_valid = 1'b1;
        load_codes = {3'b100, 3'b000, 3'b010, 3'b001};
        check_slots("F5", 0, 0, GC);
        load_valid = 1'b0;
        check_slots("F5", 1, 15, GC);

        // F6..F9: blinking, phases on, off, off, on
        blink_en = 1'b1;
        check_slots("F6", 0, 15, GD);
        check_slots("F7", 0, 15, GD_OFF);
        check_slots("F8", 0, 15, GD_OFF);
        check_slots("F9", 0, 15, GD);
        blink_en = 1'b0;

        // F10: pending word, then reset during slot 2
        check_slots("F10", 0, 0, GD);
        load_valid = 1'b1;
        load_codes = {4{3'b001}};
        check_slots("F10", 1, 1, GD);
        load_valid = 1'b0;
        chk("F10 ready pending", 32'(load_ready), 32'h0);
        check_slots("F10", 2, 9, GD);
        rst = 1'b1;
        #1;
        chk("midrst seg", 32'(seg), 32'h0);
        chk("midrst an", 32'(an), 32'h0);
        chk("midrst frame", 32'(frame), 32'h0);
        chk("midrst ready", 32'(load_ready), 32'h1);
        step();
        rst = 1'b0;

        check_slots("R1", 0, 15, GALL0);
        check_slots("R2", 0, 15, GALL0);
        chk("R2 ready", 32'(load_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
